// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and limits for the instruction-memory controller
// Purpose: response record carried through the latency pipeline, NOP encoding and
// the parameter limits checked at elaboration.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam int          IMEM_DATA_W_MAX = 64;
  localparam int          LATENCY_MIN     = 1;
  localparam int          LATENCY_MAX     = 4;
  localparam int          OUTSTANDING_MIN = 1;

  // Data field sized for the widest supported word; narrower configs use the low bits.
  typedef struct packed {
    logic                       valid;
    logic [IMEM_DATA_W_MAX-1:0] data;
    logic                       err;
  } imem_resp_t;

endpackage

// File: rtl/imem_ctrl_if.sv
// rtl/imem_ctrl_if.sv - fetch and backdoor-load bus of the instruction memory
// Purpose: bundles the req/gnt/rvalid fetch handshake and the program-load port.
// Signals: instr_req_in, instr_addr_in, instr_gnt_o, instr_rvalid_o, instr_rdata_o,
//          ld_we_in, ld_addr_in, ld_data_in.
// Modports: master (fetch stage / loader side), slave (memory side).
interface imem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req_in;
  logic [ADDR_W-1:0] instr_addr_in;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              ld_we_in;
  logic [ADDR_W-1:0] ld_addr_in;
  logic [DATA_W-1:0] ld_data_in;

  modport master (
    output instr_req_in, instr_addr_in, ld_we_in, ld_addr_in, ld_data_in,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );

  modport slave (
    input  instr_req_in, instr_addr_in, ld_we_in, ld_addr_in, ld_data_in,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );
endinterface

// File: rtl/imem_ctrl_lat_pipe.sv
// rtl/imem_ctrl_lat_pipe.sv - fixed-depth response delay line
// Purpose: delays each accepted response by exactly LATENCY cycles, in order.
// Ports: clk, rst_n (async active-low flush), in_resp (stage-0 input),
//        out_resp (last stage; data holds the last valid word when valid=0).
module imem_lat_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  imem_resp_t in_resp,
  output imem_resp_t out_resp
);

  imem_resp_t stage_q [LATENCY];
  imem_resp_t stage_d [LATENCY];
  imem_resp_t chain   [LATENCY];

  // Valid bits shift every cycle; payload only moves with a valid entry so the
  // last stage keeps the most recently returned word between responses.
  always_comb begin
    chain[0] = in_resp;
    for (int i = 1; i < LATENCY; i++) begin
      chain[i] = stage_q[i-1];
    end
    for (int i = 0; i < LATENCY; i++) begin
      stage_d[i]       = stage_q[i];
      stage_d[i].valid = 1'b0;
      if (chain[i].valid) begin
        stage_d[i] = chain[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_resp = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - parametrised instruction memory serving the fetch stage
// Purpose: word storage with backdoor load, pipelined in-order reads of fixed
// latency, outstanding-request limit and periodic grant back-pressure.
// Ports: req (clock), reset (async active-low), bus (imem_ctrl_if.slave),
//        busy_o (requests in flight), instr_err_o (only with IMEM_MISALIGN_ERR_EN:
//        misaligned fetch flag, returned with a NOP word).
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  parameter int DEPTH            = 8192,
  parameter int LATENCY          = 1,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int GNT_STALL_PERIOD = 0
) (
  input  logic        req,
  input  logic        reset,
  imem_ctrl_if.slave  bus,
`ifdef IMEM_MISALIGN_ERR_EN
  output logic        instr_err_o,
`endif
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SC_W  = (GNT_STALL_PERIOD < 2) ? 1 : $clog2(GNT_STALL_PERIOD + 1);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("imem_ctrl: LATENCY must be within 1..4");
  end
  if (MAX_OUTSTANDING < OUTSTANDING_MIN || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
    $error("imem_ctrl: MAX_OUTSTANDING must be within 1..LATENCY+1");
  end
  if ((DATA_W % 8) != 0 || DATA_W > IMEM_DATA_W_MAX) begin : g_bad_data_w
    $error("imem_ctrl: DATA_W must be a multiple of 8 and at most 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W < IDX_W + 2) begin : g_bad_depth
    $error("imem_ctrl: DEPTH must be a power of two addressable by ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  rd_idx, ld_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic              stall_q, stall_d;
  logic              full, accept, retire, misalign;
  imem_resp_t        pipe_in, pipe_out;

  // Upper address bits alias (wrap-around); byte offset is never decoded.
  assign rd_idx = bus.instr_addr_in[IDX_W+1:2];
  assign ld_idx = bus.ld_addr_in[IDX_W+1:2];

  // A response leaving this cycle frees its slot, so a new grant may take it.
  assign retire          = pipe_out.valid;
  assign full            = (count_q == CNT_W'(MAX_OUTSTANDING)) & ~retire;
  assign bus.instr_gnt_o = bus.instr_req_in & ~full & ~stall_q & reset;
  assign accept          = bus.instr_gnt_o;

`ifdef IMEM_MISALIGN_ERR_EN
  assign misalign = (bus.instr_addr_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Combinational read against the pre-edge array gives read-before-write on a
  // same-edge backdoor load of the same word.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept;
    pipe_in.err   = misalign;
    pipe_in.data  = IMEM_DATA_W_MAX'(misalign ? DATA_W'(NOP_INSTR) : mem_q[rd_idx]);
  end

  always_comb begin
    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && retire) begin
      count_d = count_q - CNT_W'(1);
    end

    // Period reached on an accept: clear and block the grant for the next cycle.
    stall_cnt_d = stall_cnt_q;
    stall_d     = 1'b0;
    if (GNT_STALL_PERIOD != 0 && accept) begin
      if (stall_cnt_q + SC_W'(1) == SC_W'(GNT_STALL_PERIOD)) begin
        stall_cnt_d = '0;
        stall_d     = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + SC_W'(1);
      end
    end
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  // Storage survives reset so a loaded program stays in place.
  always_ff @(posedge req) begin
    if (bus.ld_we_in) begin
      mem_q[ld_idx] <= bus.ld_data_in;
    end
  end

  imem_lat_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (req),
    .rst_n    (reset),
    .in_resp  (pipe_in),
    .out_resp (pipe_out)
  );

  assign bus.instr_rvalid_o = pipe_out.valid;
  assign bus.instr_rdata_o  = pipe_out.data[DATA_W-1:0];
  assign busy_o             = (count_q != '0);

  // Address bits outside the word index and spare payload bits are not decoded.
  logic unused_bits;
`ifdef IMEM_MISALIGN_ERR_EN
  assign instr_err_o = pipe_out.valid & pipe_out.err;
  assign unused_bits = ^{bus.instr_addr_in, bus.ld_addr_in, pipe_out.data};
`else
  assign unused_bits = ^{bus.instr_addr_in, bus.ld_addr_in, pipe_out.data, pipe_out.err};
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed self-checking bench for imem_ctrl
// Purpose: four configurations (latency 1/3/2, outstanding limits, grant stall)
// exercised by one linear stimulus sequence.
module tb_imem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  imem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
  imem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b_if ();
  imem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) c_if ();
  imem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) d_if ();
  logic a_busy, b_busy, c_busy, d_busy;
`ifdef IMEM_MISALIGN_ERR_EN
  logic a_err, b_err, c_err, d_err;
`endif

  imem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(1), .MAX_OUTSTANDING(2), .GNT_STALL_PERIOD(0))
    u_a (.req(clk), .reset(rst_n), .bus(a_if),
`ifdef IMEM_MISALIGN_ERR_EN
         .instr_err_o(a_err),
`endif
         .busy_o(a_busy));
  imem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(3), .MAX_OUTSTANDING(4), .GNT_STALL_PERIOD(0))
    u_b (.req(clk), .reset(rst_n), .bus(b_if),
`ifdef IMEM_MISALIGN_ERR_EN
         .instr_err_o(b_err),
`endif
         .busy_o(b_busy));
  imem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(2), .MAX_OUTSTANDING(1), .GNT_STALL_PERIOD(0))
    u_c (.req(clk), .reset(rst_n), .bus(c_if),
`ifdef IMEM_MISALIGN_ERR_EN
         .instr_err_o(c_err),
`endif
         .busy_o(c_busy));
  imem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(1), .MAX_OUTSTANDING(2), .GNT_STALL_PERIOD(2))
    u_d (.req(clk), .reset(rst_n), .bus(d_if),
`ifdef IMEM_MISALIGN_ERR_EN
         .instr_err_o(d_err),
`endif
         .busy_o(d_busy));

  logic [31:0] words [5] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213, 32'h0000_0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int gcount, rcount, k;
    logic exp_g, exp_r;

    a_if.instr_req_in = 1'b1; a_if.instr_addr_in = '0; a_if.ld_we_in = 1'b0; a_if.ld_addr_in = '0; a_if.ld_data_in = '0;
    b_if.instr_req_in = 1'b0; b_if.instr_addr_in = '0; b_if.ld_we_in = 1'b0; b_if.ld_addr_in = '0; b_if.ld_data_in = '0;
    c_if.instr_req_in = 1'b0; c_if.instr_addr_in = '0; c_if.ld_we_in = 1'b0; c_if.ld_addr_in = '0; c_if.ld_data_in = '0;
    d_if.instr_req_in = 1'b0; d_if.instr_addr_in = '0; d_if.ld_we_in = 1'b0; d_if.ld_addr_in = '0; d_if.ld_data_in = '0;

    // Reset state, with a request pending that must not be granted.
    #12;
    chk("rst_gnt", 32'(a_if.instr_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(a_if.instr_rvalid_o), 32'd0);
    chk("rst_rdata", a_if.instr_rdata_o, 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    a_if.instr_req_in = 1'b0;

    // Backdoor program load into every instance.
    for (int i = 0; i < 5; i++) begin
      tick();
      a_if.ld_we_in = 1'b1; a_if.ld_addr_in = 32'(i * 4); a_if.ld_data_in = words[i];
      b_if.ld_we_in = 1'b1; b_if.ld_addr_in = 32'(i * 4); b_if.ld_data_in = words[i];
      c_if.ld_we_in = 1'b1; c_if.ld_addr_in = 32'(i * 4); c_if.ld_data_in = words[i];
      d_if.ld_we_in = 1'b1; d_if.ld_addr_in = 32'(i * 4); d_if.ld_data_in = words[i];
    end
    tick();
    a_if.ld_we_in = 1'b0; b_if.ld_we_in = 1'b0; c_if.ld_we_in = 1'b0; d_if.ld_we_in = 1'b0;

    // Latency 1 single read, then hold of rdata after the response.
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h0;
    sample(); chk("t1_gnt", 32'(a_if.instr_gnt_o), 32'd1); chk("t1_rvalid_early", 32'(a_if.instr_rvalid_o), 32'd0);
    tick(); a_if.instr_req_in = 1'b0;
    sample(); chk("t1_rvalid", 32'(a_if.instr_rvalid_o), 32'd1); chk("t1_rdata", a_if.instr_rdata_o, 32'h0010_0093);
    chk("t1_busy", 32'(a_busy), 32'd1);
    tick();
    sample(); chk("t1_rvalid_low", 32'(a_if.instr_rvalid_o), 32'd0); chk("t1_rdata_hold", a_if.instr_rdata_o, 32'h0010_0093);
    chk("t1_idle", 32'(a_busy), 32'd0);

    // Address wrap: 0x104 aliases word 1 in a 64-word memory.
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h104;
    sample(); chk("wrap_gnt", 32'(a_if.instr_gnt_o), 32'd1);
    tick(); a_if.instr_req_in = 1'b0;
    sample(); chk("wrap_rvalid", 32'(a_if.instr_rvalid_o), 32'd1); chk("wrap_rdata", a_if.instr_rdata_o, 32'h0020_0113);

    // Same-edge load and read of 0x10 returns the old word.
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h10;
    a_if.ld_we_in = 1'b1; a_if.ld_addr_in = 32'h10; a_if.ld_data_in = 32'hDEAD_BEEF;
    sample(); chk("rbw_gnt", 32'(a_if.instr_gnt_o), 32'd1);
    tick(); a_if.instr_req_in = 1'b0; a_if.ld_we_in = 1'b0;
    sample(); chk("rbw_rvalid", 32'(a_if.instr_rvalid_o), 32'd1); chk("rbw_old", a_if.instr_rdata_o, 32'h0);
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h10;
    sample();
    tick(); a_if.instr_req_in = 1'b0;
    sample(); chk("rbw_new_rvalid", 32'(a_if.instr_rvalid_o), 32'd1); chk("rbw_new", a_if.instr_rdata_o, 32'hDEAD_BEEF);

    // Latency 3, four back-to-back requests, responses on cycles 3..6.
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick(); b_if.instr_req_in = (cyc < 4); b_if.instr_addr_in = 32'(cyc * 4);
      sample();
      exp_g = (cyc < 4);
      exp_r = (cyc >= 3) && (cyc <= 6);
      chk($sformatf("t2_gnt_c%0d", cyc), 32'(b_if.instr_gnt_o), 32'(exp_g));
      chk($sformatf("t2_rvalid_c%0d", cyc), 32'(b_if.instr_rvalid_o), 32'(exp_r));
      if (exp_r) chk($sformatf("t2_rdata_c%0d", cyc), b_if.instr_rdata_o, words[cyc-3]);
    end

    // Latency 2, one outstanding: grant every other cycle, no loss or duplication.
    gcount = 0; rcount = 0; k = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      tick(); c_if.instr_req_in = (cyc < 8); c_if.instr_addr_in = 32'(k * 4);
      sample();
      exp_g = (cyc < 8) && (cyc % 2 == 0);
      exp_r = (cyc >= 2) && (cyc <= 8) && (cyc % 2 == 0);
      chk($sformatf("t3_gnt_c%0d", cyc), 32'(c_if.instr_gnt_o), 32'(exp_g));
      chk($sformatf("t3_rvalid_c%0d", cyc), 32'(c_if.instr_rvalid_o), 32'(exp_r));
      if (c_if.instr_gnt_o) gcount++;
      if (c_if.instr_rvalid_o) begin
        if (rcount < 4) chk($sformatf("t3_rdata_%0d", rcount), c_if.instr_rdata_o, words[rcount]);
        rcount++;
      end
      if (exp_g) k++;
    end
    chk("t3_gnt_count", 32'(gcount), 32'd4);
    chk("t3_rvalid_count", 32'(rcount), 32'd4);

    // Grant stall every 2 accepts: pattern 1,1,0 repeating.
    gcount = 0; rcount = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick(); d_if.instr_req_in = (cyc < 9); d_if.instr_addr_in = 32'h8;
      sample();
      exp_g = (cyc < 9) && (cyc % 3 != 2);
      chk($sformatf("t4_gnt_c%0d", cyc), 32'(d_if.instr_gnt_o), 32'(exp_g));
      if (d_if.instr_gnt_o) gcount++;
      if (d_if.instr_rvalid_o) begin
        chk($sformatf("t4_rdata_%0d", rcount), d_if.instr_rdata_o, 32'h0030_0193);
        rcount++;
      end
    end
    chk("t4_gnt_count", 32'(gcount), 32'd6);
    chk("t4_rvalid_count", 32'(rcount), 32'd6);

    // Reset with two requests in flight drops them.
    tick(); b_if.instr_req_in = 1'b1; b_if.instr_addr_in = 32'h0;
    sample();
    tick(); b_if.instr_addr_in = 32'h4;
    sample();
    tick(); b_if.instr_req_in = 1'b0;
    sample(); chk("t6_busy_inflight", 32'(b_busy), 32'd1); chk("t6_rvalid_wait", 32'(b_if.instr_rvalid_o), 32'd0);
    tick();
    sample(); chk("t6_rvalid_first", 32'(b_if.instr_rvalid_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rvalid_async", 32'(b_if.instr_rvalid_o), 32'd0);
    chk("t6_busy_async", 32'(b_busy), 32'd0);
    chk("t6_rdata_async", b_if.instr_rdata_o, 32'd0);
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    rcount = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      sample();
      if (b_if.instr_rvalid_o) rcount++;
    end
    chk("t6_no_rvalid_after", 32'(rcount), 32'd0);
    chk("t6_busy_after", 32'(b_busy), 32'd0);

`ifdef IMEM_MISALIGN_ERR_EN
    // Misaligned fetch returns NOP with the error flag; aligned fetch clears it.
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h2;
    sample(); chk("mis_gnt", 32'(a_if.instr_gnt_o), 32'd1);
    tick(); a_if.instr_req_in = 1'b0;
    sample(); chk("mis_rvalid", 32'(a_if.instr_rvalid_o), 32'd1);
    chk("mis_err", 32'(a_err), 32'd1); chk("mis_rdata", a_if.instr_rdata_o, 32'h0000_0013);
    tick(); a_if.instr_req_in = 1'b1; a_if.instr_addr_in = 32'h4;
    sample();
    tick(); a_if.instr_req_in = 1'b0;
    sample(); chk("aln_err", 32'(a_err), 32'd0); chk("aln_rdata", a_if.instr_rdata_o, 32'h0020_0113);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
